// File: rtl/spi_slave_top_if.sv
// spi_slave_top_if: Wishbone register bus between a bus master and the SPI slave
interface spi_slave_top_if;
  logic        wb_cyc_in;
  logic        wb_stb_in;
  logic        wb_we_in;
  logic [4:0]  wb_adr_in;
  logic [31:0] wb_dat_in;
  logic [3:0]  wb_sel_in;
  logic [31:0] wb_dat_o;
  logic        wb_ack_out;
  logic        wb_int_o;
  modport master(output wb_cyc_in, wb_stb_in, wb_we_in, wb_adr_in, wb_dat_in, wb_sel_in,
                 input wb_dat_o, wb_ack_out, wb_int_o);
  modport slave(input wb_cyc_in, wb_stb_in, wb_we_in, wb_adr_in, wb_dat_in, wb_sel_in,
                output wb_dat_o, wb_ack_out, wb_int_o);
endinterface

// File: rtl/spi_slave_top.sv
// spi_slave_top: oversampling SPI slave with Wishbone registers; SPI_SLAVE_OVERRUN_EN keeps the old RX word on overrun
module spi_slave_top #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_in,
  input  logic             wb_rst_in,
  spi_slave_top_if.slave   wb,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_d, ss_d, sclk_s, ss_s, mosi_s, rise, fall;
  logic [4:0] char_len, msb_idx, rx_cnt;
  logic en, rx_neg, tx_neg, lsb, ie;
  logic [31:0] tx_hold, rx_hold, tx_sh, rx_sh, tx_sh_nxt, rx_sh_nxt, rdata;
  logic txf, rxf, unr, ovr, busy, rx_edge, tx_edge, done, start;
  logic req, wr, rd, a_data, a_ctrl, a_stat;
  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign ss_s    = ss_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign busy    = state == BUSY;
  assign msb_idx = char_len - 5'd1;
  assign rx_edge = busy & (rx_neg ? fall : rise);
  // output only advances once the current word has seen an rx edge, which makes both phases work
  assign tx_edge = busy & (tx_neg ? fall : rise) & |rx_cnt;
  assign done    = rx_edge & (rx_cnt == msb_idx);
  assign start   = (~busy & en & ss_d & ~ss_s) | (done & ~ss_s);
  assign req     = wb.wb_cyc_in & wb.wb_stb_in & ~wb.wb_ack_out;
  assign wr      = req & wb.wb_we_in;
  assign rd      = req & ~wb.wb_we_in;
  assign a_data  = wb.wb_adr_in == 5'h00;
  assign a_ctrl  = wb.wb_adr_in == 5'h10;
  assign a_stat  = wb.wb_adr_in == 5'h14;
  assign miso_oe = en & ~ss_s;
  always_comb begin
    state_nxt = start ? BUSY : ss_s ? IDLE : state;
    rx_sh_nxt = ~rx_edge ? rx_sh : lsb ? (rx_sh | (32'(mosi_s) << rx_cnt)) : {rx_sh[30:0], mosi_s};
    tx_sh_nxt = start ? (txf ? tx_hold : 32'h0) : ~tx_edge ? tx_sh : lsb ? tx_sh >> 1 : tx_sh << 1;
    rdata = a_data ? rx_hold
          : a_ctrl ? {19'h0, ie, lsb, tx_neg, rx_neg, en, 3'h0, char_len}
          : a_stat ? {27'h0, unr, ovr, busy, ~txf, rxf} : 32'h0;
  end
  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      {sclk_q, ss_q, mosi_q, sclk_d, ss_d} <= '0;
      state <= IDLE;
      {char_len, en, rx_neg, tx_neg, lsb, ie} <= '0;
      {tx_hold, rx_hold, tx_sh, rx_sh, rx_cnt} <= '0;
      {txf, rxf, unr, miso} <= '0;
      wb.wb_ack_out <= 1'b0;
      wb.wb_dat_o <= 32'h0;
      wb.wb_int_o <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
      state <= state_nxt;
      tx_sh <= tx_sh_nxt;
      miso <= lsb ? tx_sh_nxt[0] : tx_sh_nxt[msb_idx];
      rx_sh <= start ? 32'h0 : rx_sh_nxt;
      rx_cnt <= start ? 5'd0 : rx_edge ? rx_cnt + 5'd1 : rx_cnt;
      txf <= (wr & a_data) | (txf & ~start);
      rxf <= done | (rxf & ~(rd & a_data));
      unr <= (start & ~txf) | (unr & ~(wr & a_stat & wb.wb_dat_in[4]));
      if (wr & a_data)
        for (int i = 0; i < 4; i++)
          if (wb.wb_sel_in[i]) tx_hold[8*i+:8] <= wb.wb_dat_in[8*i+:8];
      if (wr & a_ctrl & ~busy & wb.wb_sel_in[0]) char_len <= wb.wb_dat_in[4:0];
      if (wr & a_ctrl & ~busy & wb.wb_sel_in[1]) {ie, lsb, tx_neg, rx_neg, en} <= wb.wb_dat_in[12:8];
`ifdef SPI_SLAVE_OVERRUN_EN
      if (done & ~(rxf & ~(rd & a_data))) rx_hold <= rx_sh_nxt;
`else
      if (done) rx_hold <= rx_sh_nxt;
`endif
      wb.wb_ack_out <= req;
      wb.wb_dat_o <= rd ? rdata : 32'h0;
      wb.wb_int_o <= ie & (rxf | ovr | unr);
    end
  end
`ifdef SPI_SLAVE_OVERRUN_EN
  // a read in the completion cycle frees the holding register, so that case is not an overrun
  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) ovr <= 1'b0;
    else ovr <= (done & rxf & ~(rd & a_data)) | (ovr & ~(wr & a_stat & wb.wb_dat_in[3]));
  end
`else
  assign ovr = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_top.sv
// tb_spi_slave_top: directed bench driving an SPI master model and Wishbone accesses
module tb_spi_slave_top;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe;
  int checks = 0, errors = 0;
  logic [31:0] q, mrx;
  spi_slave_top_if wb();
  spi_slave_top #(.SYNC_STAGES(2)) dut (
    .wb_clk_in(clk), .wb_rst_in(rst_n), .wb(wb),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe));
  always #5 clk = ~clk;

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] r);
    logic got;
    got = 1'b0;
    @(negedge clk);
    wb.wb_cyc_in = 1'b1; wb.wb_stb_in = 1'b1; wb.wb_we_in = we;
    wb.wb_adr_in = adr; wb.wb_dat_in = d; wb.wb_sel_in = sel;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      got = wb.wb_ack_out;
    end
    r = wb.wb_dat_o;
    wb.wb_cyc_in = 1'b0; wb.wb_stb_in = 1'b0; wb.wb_we_in = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL wb_ack_timeout adr=%h got no ack required ack", adr); end
  endtask
  task automatic wb_wr(input logic [4:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    wb_xfer(1'b1, adr, d, sel, r);
  endtask
  task automatic wb_rd(input logic [4:0] adr, output logic [31:0] r);
    wb_xfer(1'b0, adr, 32'h0, 4'hf, r);
  endtask
  task automatic half();
    repeat (8) @(posedge clk);
  endtask
  task automatic ss_low();
    ss_n = 1'b0; half();
  endtask
  task automatic ss_high();
    ss_n = 1'b1; half(); half();
  endtask
  task automatic spi_word(input logic [31:0] mtx, input int nbits, input bit lsbf, input bit cpha,
                          output logic [31:0] r);
    r = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      int b = lsbf ? i : nbits - 1 - i;
      if (!cpha) begin
        mosi = mtx[b]; half(); r[b] = miso; sclk = 1'b1; half(); sclk = 1'b0;
      end else begin
        sclk = 1'b1; mosi = mtx[b]; half(); r[b] = miso; sclk = 1'b0; half();
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    checks++; if ({wb.wb_ack_out, wb.wb_int_o, miso, miso_oe} !== 4'b0) begin errors++; $display("FAIL reset_outs got %b required 0000", {wb.wb_ack_out, wb.wb_int_o, miso, miso_oe}); end
    checks++; if (wb.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h required 0", wb.wb_dat_o); end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    wb_rd(5'h10, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h required 0", q); end
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL reset_status got %h required 2", q); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_rx got %h required 0", q); end
  endtask

  task automatic test_mode0();
    wb_wr(5'h10, 32'h1508, 4'h3);
    wb_rd(5'h10, q);
    checks++; if (q !== 32'h1508) begin errors++; $display("FAIL m0_ctrl got %h required 1508", q); end
    wb_wr(5'h00, 32'hA5, 4'hf);
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL m0_txf got %h required 0", q); end
    ss_low();
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL m0_oe got %b required 1", miso_oe); end
    spi_word(32'h3C, 8, 1'b0, 1'b0, mrx);
    checks++; if (mrx[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_miso got %h required a5", mrx[7:0]); end
    ss_high();
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h13) begin errors++; $display("FAIL m0_status got %h required 13", q); end
    wb_wr(5'h14, 32'h10, 4'hf);
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h3) begin errors++; $display("FAIL m0_w1c got %h required 3", q); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wb.wb_int_o !== 1'b1) begin errors++; $display("FAIL m0_int_set got %b required 1", wb.wb_int_o); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'h3C) begin errors++; $display("FAIL m0_rx got %h required 3c", q); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wb.wb_int_o !== 1'b0) begin errors++; $display("FAIL m0_int_clr got %b required 0", wb.wb_int_o); end
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL m0_status2 got %h required 2", q); end
  endtask

  task automatic test_mode1_lsb32();
    wb_wr(5'h10, 32'hB00, 4'h3);
    wb_wr(5'h00, 32'h12345678, 4'hf);
    ss_low();
    spi_word(32'hDEADBEEF, 32, 1'b1, 1'b1, mrx);
    ss_high();
    checks++; if (mrx !== 32'h12345678) begin errors++; $display("FAIL m1_miso got %h required 12345678", mrx); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL m1_rx got %h required deadbeef", q); end
    wb_wr(5'h14, 32'h10, 4'hf);
  endtask

  task automatic test_underrun();
    wb_wr(5'h10, 32'h508, 4'h3);
    ss_low();
    spi_word(32'h5A, 8, 1'b0, 1'b0, mrx);
    ss_high();
    checks++; if (mrx[7:0] !== 8'h00) begin errors++; $display("FAIL unr_miso got %h required 00", mrx[7:0]); end
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h13) begin errors++; $display("FAIL unr_status got %h required 13", q); end
    checks++; if (wb.wb_int_o !== 1'b0) begin errors++; $display("FAIL unr_int got %b required 0", wb.wb_int_o); end
    wb_wr(5'h14, 32'h10, 4'hf);
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h3) begin errors++; $display("FAIL unr_w1c got %h required 3", q); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'h5A) begin errors++; $display("FAIL unr_rx got %h required 5a", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rx, exp_st;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_rx = 32'h11; exp_st = 32'h1B;
`else
    exp_rx = 32'h22; exp_st = 32'h13;
`endif
    ss_low();
    spi_word(32'h11, 8, 1'b0, 1'b0, mrx);
    spi_word(32'h22, 8, 1'b0, 1'b0, mrx);
    ss_high();
    wb_rd(5'h14, q);
    checks++; if (q !== exp_st) begin errors++; $display("FAIL b2b_status got %h required %h", q, exp_st); end
    wb_rd(5'h00, q);
    checks++; if (q !== exp_rx) begin errors++; $display("FAIL b2b_rx got %h required %h", q, exp_rx); end
    wb_wr(5'h14, 32'h18, 4'hf);
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL b2b_w1c got %h required 2", q); end
  endtask

  task automatic test_abort();
    wb_wr(5'h00, 32'h81, 4'hf);
    ss_low();
    spi_word(32'h1F, 5, 1'b0, 1'b0, mrx);
    ss_high();
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL abort_status got %h required 2", q); end
    wb_wr(5'h00, 32'hC3, 4'hf);
    ss_low();
    spi_word(32'h96, 8, 1'b0, 1'b0, mrx);
    ss_high();
    checks++; if (mrx[7:0] !== 8'hC3) begin errors++; $display("FAIL abort_next_miso got %h required c3", mrx[7:0]); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'h96) begin errors++; $display("FAIL abort_next_rx got %h required 96", q); end
    wb_wr(5'h14, 32'h10, 4'hf);
  endtask

  task automatic test_reset_mid();
    wb_wr(5'h00, 32'h77, 4'hf);
    ss_low();
    wb_wr(5'h10, 32'h0, 4'h3);
    wb_rd(5'h10, q);
    checks++; if (q !== 32'h508) begin errors++; $display("FAIL busy_ctrl got %h required 508", q); end
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h6) begin errors++; $display("FAIL busy_status got %h required 6", q); end
    spi_word(32'h7, 3, 1'b0, 1'b0, mrx);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({wb.wb_ack_out, wb.wb_int_o, miso, miso_oe} !== 4'b0) begin errors++; $display("FAIL mid_reset_outs got %b required 0000", {wb.wb_ack_out, wb.wb_int_o, miso, miso_oe}); end
    checks++; if (wb.wb_dat_o !== 32'h0) begin errors++; $display("FAIL mid_reset_dat got %h required 0", wb.wb_dat_o); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    wb_rd(5'h10, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl got %h required 0", q); end
    wb_wr(5'h10, 32'h508, 4'h3);
    spi_word(32'h3, 2, 1'b0, 1'b0, mrx);
    wb_rd(5'h14, q);
    checks++; if (q !== 32'h2) begin errors++; $display("FAIL mid_reset_nostart got %h required 2", q); end
    ss_high();
    wb_wr(5'h00, 32'hE7, 4'hf);
    ss_low();
    spi_word(32'h42, 8, 1'b0, 1'b0, mrx);
    ss_high();
    checks++; if (mrx[7:0] !== 8'hE7) begin errors++; $display("FAIL resume_miso got %h required e7", mrx[7:0]); end
    wb_rd(5'h00, q);
    checks++; if (q !== 32'h42) begin errors++; $display("FAIL resume_rx got %h required 42", q); end
  endtask

  initial begin
    wb.wb_cyc_in = 1'b0; wb.wb_stb_in = 1'b0; wb.wb_we_in = 1'b0;
    wb.wb_adr_in = 5'h0; wb.wb_dat_in = 32'h0; wb.wb_sel_in = 4'h0;
    test_reset();
    test_mode0();
    test_mode1_lsb32();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_top.md
# spi_slave_top

SPI slave peripheral with a Wishbone register interface; the responder counterpart of the team's `spi_top` SPI master. It lives in the system clock domain, oversamples the external `sclk`/`ss_n`/`mosi` pins, shifts up to 32-bit words in both directions, and buffers one RX word and one TX word. Software-visible status, interrupt and register access mirror the master so that one driver style covers both ends of the link.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `ss_n` and `mosi`; minimum 2.
- `wb_clk_in`  in  1  system clock; all logic in this domain.
- `wb_rst_in`  in  1  reset, asynchronous, active-low.
- `wb_cyc_in`, `wb_stb_in`, `wb_we_in`  in  1  Wishbone cycle, strobe and write-enable.
- `wb_adr_in`  in  5  byte address.
- `wb_dat_in`  in  32  write data.
- `wb_sel_in`  in  4  byte selects; CTRL uses [1:0] and TXDATA uses all four.
- `wb_dat_o`  out  32  registered read data.
- `wb_ack_out`  out  1  registered acknowledge.
- `wb_int_o`  out  1  interrupt, level.
- `sclk`, `ss_n`, `mosi`  in  1  asynchronous SPI pins; `ss_n` is active-low.
- `miso`  out  1  serial data to the master.
- `miso_oe`  out  1  pad output-enable, equal to EN & synchronized `ss_n` low.

## Operation
- Register map:
  - 0x00 write: TXDATA. Loads the TX holding register and sets TXF.
  - 0x00 read: RXDATA. Returns the RX holding register and clears RXF.
  - 0x10: CTRL. [4:0] char_len (0 means 32 bits), [8] EN, [9] rx_negedge, [10] tx_negedge, [11] lsb, [12] ie.
  - 0x14: STATUS. [0] RXF, [1] TXE (= ~TXF), [2] BUSY, [3] OVR, [4] UNR.
    - A write of 1 clears OVR or UNR.
  - Any other address reads 0 and ignores writes.
- CTRL writes are ignored while BUSY is set.
- Word start, on a synchronized `ss_n` fall with EN=1, or on completion of a word while `ss_n` stays low:
  - If TXF=1: shift register ← TX holding, and TXF clears.
  - If TXF=0: shift register ← 0 and UNR sets.
  - Bit counters clear and BUSY sets.
- `miso` always presents the current output bit: the MSB of the char, or bit 0 when lsb=1.
- Edges: the rx edge is the sclk falling edge if rx_negedge=1, otherwise the rising edge. The tx edge is selected the same way by tx_negedge.
- On each rx edge, `mosi` is sampled into the RX shift register.
- On each tx edge, the output bit advances, but only after at least one rx edge of the current word has occurred. This rule covers both clock phases.
- Word completion is the char_len-th rx edge: RX shift → RX holding, and RXF sets.
- Overrun (RXF already set at completion): see Configuration.
- `ss_n` rises mid-word: the partial word is discarded, there is no RXF, and BUSY clears.
  - An already-consumed TX word is not restored.
- `wb_int_o` is registered and equals ie & (RXF | OVR | UNR).

## Timing
- Reset values:
  - `wb_dat_o`=0, `wb_ack_out`=0, `wb_int_o`=0.
  - `miso`=0, `miso_oe`=0.
  - CTRL=0, holding registers=0, TXF=0, RXF=0, OVR=0, UNR=0.
- Pin latency: SYNC_STAGES cycles for synchronization plus 1 cycle for edge detection.
  - `miso` updates 1 cycle after the detected edge.
  - Requirement: every sclk high and low phase is ≥ SYNC_STAGES+2 `wb_clk_in` cycles, i.e. ≥4 for the default.
- Wishbone:
  - `wb_ack_out` <= cyc & stb & ~ack, which gives single-cycle acks and back-to-back accesses no faster than every 2 cycles.
  - Side effects (register writes, RXF clear, W1C) occur only in the cycle where cyc & stb & ~ack.
  - `wb_dat_o` is valid together with `wb_ack_out`.
- Simultaneous events:
  - Word completion and RXDATA read in the same cycle: the read returns the old word, and RXF stays 1 with the new word.
  - TXDATA write and word start in the same cycle: the start uses the old TXF. If TXF was 0, zeros are shifted and UNR sets; the written word stays in holding with TXF=1.
  - W1C clearing and a flag being set in the same cycle: set wins.
- Reset asserted mid-transfer: immediate return to reset values.
  - After reset release, the first word starts only on a fresh `ss_n` fall.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - Completion with RXF=1 keeps the old RX holding word, discards the new word and sets OVR.
- `SPI_SLAVE_OVERRUN_EN` undefined:
  - The new word overwrites RX holding.
  - OVR reads 0 and is not set.
  - The interrupt term for OVR is absent.

## Test plan
- Mode 0 (rx_negedge=0, tx_negedge=1), char_len=8, TXDATA=0xA5, master sends 0x3C MSB-first → master receives 0xA5; RXDATA=0x3C; RXF=1; TXE=1; with ie=1, `wb_int_o`=1 until the RXDATA read.
- Mode 1 (rx_negedge=1, tx_negedge=0), lsb=1, char_len=0 (32 bits), TXDATA=0x12345678, master sends 0xDEADBEEF → master receives 0x12345678 LSB-first; RXDATA=0xDEADBEEF.
- No TXDATA write, 8-bit transfer → master receives 0x00; UNR=1; writing 0x10 to STATUS clears UNR.
- Two 8-bit words under one `ss_n` low (0x11 then 0x22), RXDATA not read between them → with the macro defined, RXDATA=0x11 and OVR=1; without it, RXDATA=0x22 and OVR reads 0.
- `ss_n` raised after 5 of 8 bits → RXF=0, BUSY=0; the next full word is received correctly.
- Reset pulsed mid-word → all outputs return to their reset values; the transfer resumes only on the next `ss_n` fall; CTRL writes during BUSY are ignored.
